// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// Maps the controller's ALU operation class and funct fields to an ALU control code.
module riscv_alu_decoder
    import riscv_mc_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  aluop_t                  i_aluop,
    input  logic [2:0]              i_funct3,
    input  logic                    i_op5,
    input  logic                    i_funct7b5,
    output logic [ALU_CTRL_W-1:0]   o_alu_control,
    output logic                    o_illegal
);

    logic [2:0] code;

    always_comb begin
        code      = ALU_ADD;
        o_illegal = 1'b0;
        case (i_aluop)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            default: begin
                case (i_funct3)
                    3'b000:  code = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  code = ALU_SLT;
                    3'b110:  code = ALU_OR;
                    3'b111:  code = ALU_AND;
                    // Unsupported funct3 keeps the harmless add code while the FSM traps.
                    default: o_illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign o_alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/riscv_mc_controller.sv
// Multi-cycle RV32I control FSM: sequences a shared memory port and ALU,
// traps on illegal opcodes or memory timeouts, and counts retired instructions.
module riscv_mc_controller
    import riscv_mc_pkg::*;
#(
    parameter int ALU_CTRL_W     = 3,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [6:0]            i_op,
    input  logic [2:0]            i_funct3,
    input  logic                  i_funct7b5,
    input  logic                  i_zero,
    input  logic                  i_mem_ready,
    output logic                  o_mem_req,
    output logic                  o_mem_write,
    output logic                  o_adr_src,
    output logic                  o_ir_write,
    output logic                  o_pc_write,
    output logic                  o_reg_write,
    output logic [1:0]            o_result_src,
    output logic [1:0]            o_alu_src_a,
    output logic [1:0]            o_alu_src_b,
    output logic [1:0]            o_imm_src,
    output logic [ALU_CTRL_W-1:0] o_alu_control,
    output logic                  o_trap,
    output logic [CNT_W-1:0]      o_retired
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    aluop_t aluop;
    logic   alu_illegal;
    logic   mem_req_st, mem_write_st, ir_write_st, pc_write_st, reg_write_st;
    logic   timeout_hit;
    logic   retire;

    riscv_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
        .i_aluop       (aluop),
        .i_funct3      (i_funct3),
        .i_op5         (i_op[5]),
        .i_funct7b5    (i_funct7b5),
        .o_alu_control (o_alu_control),
        .o_illegal     (alu_illegal)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    // A ready arriving in the limit cycle wins because timeout requires ready low.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && mem_req_st && !i_mem_ready &&
                         (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (i_mem_ready) state_d = DECODE;
            DECODE: begin
                case (i_op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = TRAP;
                endcase
            end
            MEMADR:   state_d = (i_op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (i_mem_ready) state_d = MEMWB;
            MEMWRITE: if (i_mem_ready) state_d = FETCH;
            MEMWB:    state_d = FETCH;
            EXECR,
            EXECI:    state_d = alu_illegal ? TRAP : ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = ALUWB;
            default:  state_d = TRAP;
        endcase
        if (timeout_hit) state_d = TRAP;

        if (state_d != state_q || i_mem_ready || !mem_req_st) wait_d = '0;
        else                                                  wait_d = wait_q + WAIT_W'(1);

        retire = (state_d == FETCH) &&
                 (state_q == MEMWRITE || state_q == MEMWB || state_q == ALUWB || state_q == BEQ);
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_comb begin
        mem_req_st   = 1'b0;
        mem_write_st = 1'b0;
        ir_write_st  = 1'b0;
        pc_write_st  = 1'b0;
        reg_write_st = 1'b0;
        o_adr_src    = 1'b0;
        o_result_src = RES_ALUOUT;
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_RD2;
        aluop        = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                mem_req_st   = 1'b1;
                ir_write_st  = i_mem_ready;
                pc_write_st  = i_mem_ready;
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALU;
            end
            DECODE: begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                mem_req_st = 1'b1;
                o_adr_src  = 1'b1;
            end
            MEMWRITE: begin
                mem_req_st   = 1'b1;
                mem_write_st = 1'b1;
                o_adr_src    = 1'b1;
            end
            MEMWB: begin
                o_result_src = RES_DATA;
                reg_write_st = 1'b1;
            end
            EXECR, EXECI: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_src_b = (state_q == EXECI) ? SRCB_IMM : SRCB_RD2;
                aluop       = ALUOP_FUNCT;
            end
            ALUWB: reg_write_st = 1'b1;
            BEQ: begin
                o_alu_src_a = SRCA_RD1;
                aluop       = ALUOP_SUB;
                pc_write_st = i_zero;
            end
            JAL: begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_FOUR;
                pc_write_st = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are forced low while reset is held, since state already reads FETCH.
    assign o_mem_req   = mem_req_st   & ~i_rst;
    assign o_mem_write = mem_write_st & ~i_rst;
    assign o_ir_write  = ir_write_st  & ~i_rst;
    assign o_pc_write  = pc_write_st  & ~i_rst;
    assign o_reg_write = reg_write_st & ~i_rst;
    assign o_imm_src   = imm_src_of(i_op);
    assign o_trap      = (state_q == TRAP);
    assign o_retired   = retired_q;

endmodule
